// File: rtl/pattern_line_writer_pkg.sv
// rtl/pattern_line_writer_pkg.sv - shared constants, line record type, FSM states and slot base helper
package pattern_pkg;

  // Number of pattern slots held in the pattern memory.
  localparam int NUM_PATTERNS  = 20;
  // Line records reserved per pattern slot.
  localparam int LINES_PER_PAT = 30;
  // Coordinate width of one axis in a stored line record.
  localparam int COORD_BITS    = 11;
  // Pattern memory word address width.
  localparam int ADDR_W        = 10;

  // One stored line record, x0 lands in the top bits of the memory word.
  typedef struct packed {
    logic [COORD_BITS-1:0] x0;
    logic [COORD_BITS-1:0] y0;
    logic [COORD_BITS-1:0] x1;
    logic [COORD_BITS-1:0] y1;
  } line_t;

  // Loader states: wait for start, take first vertex, stream edges,
  // close the polygon back to v0, then optionally zero-fill the slot.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIRST = 3'd1,
    ST_EDGES = 3'd2,
    ST_CLOSE = 3'd3,
    ST_PAD   = 3'd4
  } state_e;

  // First word of slot n, n*30 built from two shifts and a subtract.
  function automatic logic [ADDR_W-1:0] slot_base(input logic [4:0] n);
    logic [ADDR_W-1:0] nw;
    nw = {{(ADDR_W-5){1'b0}}, n};
    return (nw << 5) - (nw << 1);
  endfunction

endpackage

// File: rtl/pattern_line_writer_if.sv
// rtl/pattern_line_writer_if.sv - vertex stream handshake between a polygon source and the line writer
interface pattern_line_writer_if #(
  parameter int COORD_W = 11
);

  logic               v_valid;
  logic               v_ready;
  logic [COORD_W-1:0] v_x;
  logic [COORD_W-1:0] v_y;
  logic               v_last;

  // Vertex producer side.
  modport master (
    output v_valid,
    output v_x,
    output v_y,
    output v_last,
    input  v_ready
  );

  // Vertex consumer side (the line writer).
  modport slave (
    input  v_valid,
    input  v_x,
    input  v_y,
    input  v_last,
    output v_ready
  );

endinterface

// File: rtl/pattern_line_writer.sv
// rtl/pattern_line_writer.sv - turns a vertex stream into closed-polygon line records in a pattern slot (PATTERN_PAD_EN enables zero-fill of unused lines)
module pattern_line_writer #(
  parameter int COORD_W       = 11,
  parameter int LINES_PER_PAT = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           pattern_num,
  pattern_line_writer_if.slave vtx,
  output logic                 w_en,
  output logic [9:0]           w_addr,
  output logic [4*COORD_W-1:0] w_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  import pattern_pkg::*;

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] FIRST = ST_FIRST;
  localparam logic [2:0] EDGES = ST_EDGES;
  localparam logic [2:0] CLOSE = ST_CLOSE;
`ifdef PATTERN_PAD_EN
  localparam logic [2:0] PAD   = ST_PAD;
`endif

  // Index of the last line in a slot; k never passes it.
  localparam logic [4:0] LAST_K = 5'(LINES_PER_PAT - 1);

  logic [2:0]         state;
  logic [9:0]         base;
  logic [4:0]         k;
  logic [COORD_W-1:0] v0_x;
  logic [COORD_W-1:0] v0_y;
  logic [COORD_W-1:0] prev_x;
  logic [COORD_W-1:0] prev_y;
  logic               xfer;
  logic [9:0]         line_addr;

  // Handshake and status decode straight from the state register.
  always_comb begin
    vtx.v_ready = (state == FIRST) || (state == EDGES);
    busy        = (state != IDLE);
    xfer        = vtx.v_valid && vtx.v_ready;
    line_addr   = base + {5'b0, k};
  end

  // Loader FSM and registered pattern memory write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      base   <= '0;
      k      <= '0;
      v0_x   <= '0;
      v0_y   <= '0;
      prev_x <= '0;
      prev_y <= '0;
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      w_en <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pattern_num < 5'(NUM_PATTERNS)) begin
              base  <= slot_base(pattern_num);
              k     <= '0;
              state <= FIRST;
            end else begin
              err <= 1'b1;
            end
          end
        end

        FIRST: begin
          if (xfer) begin
            v0_x   <= vtx.v_x;
            v0_y   <= vtx.v_y;
            prev_x <= vtx.v_x;
            prev_y <= vtx.v_y;
            k      <= '0;
            // A single vertex is not a polygon.
            if (vtx.v_last) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= EDGES;
            end
          end
        end

        EDGES: begin
          if (xfer) begin
            w_en   <= 1'b1;
            w_addr <= line_addr;
            w_data <= {prev_x, prev_y, vtx.v_x, vtx.v_y};
            prev_x <= vtx.v_x;
            prev_y <= vtx.v_y;
            k      <= k + 5'd1;
            if (vtx.v_last && (k == 5'd0)) begin
              // Two vertices: the one edge is already written, no closure.
              err   <= 1'b1;
              state <= IDLE;
            end else if (vtx.v_last) begin
              state <= CLOSE;
            end else if (k == LAST_K - 5'd1) begin
              // Slot is full with one line left for the closing edge.
              err   <= 1'b1;
              state <= CLOSE;
            end
          end
        end

        CLOSE: begin
          w_en   <= 1'b1;
          w_addr <= line_addr;
          w_data <= {prev_x, prev_y, v0_x, v0_y};
          k      <= k + 5'd1;
`ifdef PATTERN_PAD_EN
          if (k != LAST_K) begin
            state <= PAD;
          end else begin
            done  <= 1'b1;
            state <= IDLE;
          end
`else
          done  <= 1'b1;
          state <= IDLE;
`endif
        end

`ifdef PATTERN_PAD_EN
        PAD: begin
          // Zero-length lines never register as crossings.
          w_en   <= 1'b1;
          w_addr <= line_addr;
          w_data <= '0;
          k      <= k + 5'd1;
          if (k == LAST_K) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pattern_line_writer.md
PATTERN_LINE_WRITER -- requirements
Module: pattern_line_writer

Interface
REQ-001 SHALL have parameter COORD_W, default 11, pixel coordinate width per axis.
REQ-002 SHALL have parameter LINES_PER_PAT, default 30, line records per pattern slot.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin loading a pattern.
REQ-006 SHALL have port pattern_num  input  5  target slot, sampled on accepted start.
REQ-007 SHALL have port v_valid  input  1  vertex valid.
REQ-008 SHALL have port v_ready  output  1  vertex ready.
REQ-009 SHALL have port v_x, v_y  input  11 each  vertex coordinates.
REQ-010 SHALL have port v_last  input  1  marks final vertex of the polygon.
REQ-011 SHALL have port w_en  output  1  pattern memory write strobe.
REQ-012 SHALL have port w_addr  output  10  pattern memory word address.
REQ-013 SHALL have port w_data  output  44  line record {x0,y0,x1,y1}, x0 in [43:33], y1 in [10:0].
REQ-014 SHALL have port busy, done, err  output  1 each  status; done/err are one-cycle pulses.

Function
REQ-015 SHALL use states IDLE, FIRST, EDGES, CLOSE, PAD.
REQ-016 IDLE: start with pattern_num<=19 SHALL latch base=pattern_num*30 and go to FIRST; pattern_num>19 SHALL pulse err and stay IDLE.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 v_ready SHALL be 1 only in FIRST and EDGES; a vertex transfers when v_valid&&v_ready.
REQ-019 FIRST: the accepted vertex SHALL be stored as v0 and prev, k=0, next state EDGES; no write.
REQ-020 EDGES: each accepted vertex v SHALL register a write of {prev,v} to base+k on the next cycle (w_en latency 1), then prev=v, k=k+1.
REQ-021 Accepted vertex with v_last, or the 30th vertex (k reaches 29 on this write), SHALL move to CLOSE; 30th vertex without v_last SHALL also pulse err (overflow) but still close.
REQ-022 CLOSE SHALL write {prev,v0} to base+k for one cycle, k=k+1.
REQ-023 Polygons of fewer than 3 vertices (v_last in FIRST or on 2nd vertex) SHALL pulse err and return to IDLE without CLOSE; slot contents then undefined.
REQ-024 After CLOSE, k<30 SHALL go to PAD (see REQ-030), else pulse done and return to IDLE.
REQ-025 w_addr SHALL never leave [base, base+29]; addresses SHALL be strictly increasing by 1 per write.
REQ-026 busy SHALL be 1 in every state except IDLE.

Reset
REQ-027 reset SHALL force IDLE, w_en=0, w_addr=0, w_data=0, v_ready=0, busy=0, done=0, err=0, k=0.
REQ-028 reset mid-load SHALL abandon the load without further writes; start may be accepted the cycle after reset deasserts.

Configuration
REQ-029 Macro PATTERN_PAD_EN SHALL select slot padding.
REQ-030 Defined: PAD SHALL write 44'h0 (degenerate line, never a crossing) to base+k..base+29, one per cycle, then pulse done. Undefined: PAD state absent; done pulses the cycle after the CLOSE write; unused lines retain old contents.

Structure
REQ-031 pattern_pkg SHALL hold NUM_PATTERNS=20, LINES_PER_PAT=30, line_t packed struct {x0,y0,x1,y1}, and the state enum.
REQ-032 No sub-module; base address SHALL be computed as (n<<5)-(n<<1), no multiplier.

Verification
REQ-033 start, pattern_num=2, vertices (10,10),(100,10),(100,80) last -> writes addr 60:{10,10,100,10}, 61:{100,10,100,80}, 62:{100,80,10,10}, 63..89 zero (PAD_EN), done once.
REQ-034 30 vertices, no v_last, pattern_num=19 -> addrs 570..599 written, addr 599 closes to v0, err and done pulse, no PAD.
REQ-035 pattern_num=21 start -> err one cycle, busy stays 0, no w_en.
REQ-036 v_valid toggling 1/0 each cycle during EDGES -> one write per accepted vertex, w_en exactly one cycle after each transfer.
REQ-037 reset asserted on 3rd vertex of pattern 0 -> no w_en after reset cycle, all outputs at reset values, new start accepted next cycle.
REQ-038 v_last on 2nd vertex -> one write at base, err pulse, return to IDLE, done not pulsed.
